// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer arbiter.
//   Framebuffer: 320x240 pixels at 4 bpp, packed four pixels per 16-bit word,
//   80 words per row, 19200 words in total.
//   Helpers: row_base() turns a framebuffer row into its first word address
//   using shifts only; word_nibble() extracts one packed pixel from a word.
package fb_pkg;

  localparam int FB_W          = 320;
  localparam int FB_H          = 240;
  localparam int WORDS_PER_ROW = 80;
  localparam int FB_WORDS      = 19200;
  localparam int PIX_W         = 4;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [15:0]      fb_word_t;
  typedef logic [14:0]      fb_addr_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  // row * 80 == (row << 6) + (row << 4); keeps the multiply out of the datapath.
  function automatic fb_addr_t row_base(input logic [7:0] row);
    fb_addr_t r;
    r = fb_addr_t'(row);
    return (r << 6) + (r << 4);
  endfunction

  // Pixel k of a word lives in bits [4k+3:4k].
  function automatic pix_t word_nibble(input fb_word_t w, input logic [1:0] k);
    return w[{k, 2'b00} +: PIX_W];
  endfunction

endpackage

// File: rtl/fb_scan_pipe.sv
// Display side of the framebuffer arbiter.
//   Detects fetch slots (first VGA pixel of every visible 8-pixel group),
//   forms the display word address, holds the fetched word for the rest of
//   the group and produces pix_o/active_o with a fixed 2-cycle latency.
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   x_i, y_i        scan position from the timing controller
//   ram_rdata_i     RAM read data, valid one cycle after the address
//   slot_o          this cycle belongs to the display fetch (combinational)
//   disp_addr_o     display word address for this cycle (combinational)
//   pix_o           pixel for the scan position two cycles earlier
//   active_o        pix_o lies inside the visible area
module fb_scan_pipe
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  fb_word_t  ram_rdata_i,
  output logic      slot_o,
  output fb_addr_t  disp_addr_o,
  output pix_t      pix_o,
  output logic      active_o
);

  logic       visible;
  logic       slot_p0;
  logic       vis_p0;
  logic [1:0] sel_p0;
  fb_word_t   held_word;
  fb_word_t   word_p1;

  assign visible     = (x_i < 10'(H_ACTIVE)) && (y_i < 10'(V_ACTIVE));
  assign slot_o      = visible && (x_i[2:0] == 3'd0);
  // 2x scaling in both directions: framebuffer row = y/2, word = x/8.
  assign disp_addr_o = row_base(y_i[8:1]) + fb_addr_t'(x_i[9:3]);

  // Stage p0: remember what this cycle asked for while the RAM reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_p0 <= 1'b0;
      vis_p0  <= 1'b0;
    end else begin
      slot_p0 <= slot_o;
      vis_p0  <= visible;
    end
    sel_p0 <= x_i[2:1];
  end

  // The word returned in a slot's follow-up cycle is used directly and also
  // kept for the remaining seven pixels of the group.
  assign word_p1 = slot_p0 ? ram_rdata_i : held_word;

  // Stage p1: register the selected pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_word <= '0;
      pix_o     <= '0;
      active_o  <= 1'b0;
    end else begin
      if (slot_p0) begin
        held_word <= ram_rdata_i;
      end
      active_o <= vis_p0;
      pix_o    <= vis_p0 ? word_nibble(word_p1, sel_p0) : '0;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter.
//   One single-port RAM is shared between VGA scan-out (absolute priority on
//   fetch slots), a single-pixel writer and a whole-screen clear engine.
//   Writer and clear only ever use cycles that are not fetch slots; while a
//   clear runs the writer is held off.
// Ports:
//   clk, reset                      pixel clock, synchronous active-high reset
//   x_i, y_i                        scan position from the timing controller
//   wr_valid_i/wr_ready_o           writer handshake (ready is combinational)
//   wr_x_i, wr_y_i, wr_pix_i        writer pixel coordinates and value
//   wr_drop_o                       pulse: last accepted write was off-screen
//   clr_start_i, clr_color_i        start a clear with the given fill value
//   clr_busy_o                      clear in progress
//   ram_addr_o/we/mask/wdata        RAM command, ram_rdata_i read data
//   pix_o, active_o                 display pixel, 2 cycles behind x_i/y_i
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [8:0]  wr_x_i,
  input  logic [7:0]  wr_y_i,
  input  logic [3:0]  wr_pix_i,
  output logic        wr_drop_o,
  input  logic        clr_start_i,
  input  logic [3:0]  clr_color_i,
  output logic        clr_busy_o,
  output logic [14:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_mask_o,
  output logic [15:0] ram_wdata_o,
  input  logic [15:0] ram_rdata_i,
  output logic [3:0]  pix_o,
  output logic        active_o
);

  clr_state_t state;
  fb_addr_t   clr_addr;
  pix_t       clr_color;
  logic       slot;
  fb_addr_t   disp_addr;
  logic       wr_fire;
  logic       wr_in_range;
  fb_addr_t   wr_addr;

  fb_scan_pipe #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .x_i         (x_i),
    .y_i         (y_i),
    .ram_rdata_i (ram_rdata_i),
    .slot_o      (slot),
    .disp_addr_o (disp_addr),
    .pix_o       (pix_o),
    .active_o    (active_o)
  );

  assign wr_ready_o  = !slot && (state == IDLE);
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign wr_in_range = (wr_x_i < 9'(FB_W)) && (wr_y_i < 8'(FB_H));
  assign wr_addr     = row_base(wr_y_i) + fb_addr_t'(wr_x_i[8:2]);

  // RAM command mux. Slot cycles always carry the display address; otherwise
  // the clear engine wins over the writer (the writer is not ready then anyway).
  always_comb begin
    ram_addr_o  = disp_addr;
    ram_we_o    = 1'b0;
    ram_mask_o  = 4'b0000;
    ram_wdata_o = '0;
    if (!reset && !slot) begin
      if (state == CLEAR) begin
        ram_addr_o  = clr_addr;
        ram_we_o    = 1'b1;
        ram_mask_o  = 4'b1111;
        ram_wdata_o = {4{clr_color}};
      end else if (wr_fire && wr_in_range) begin
        ram_addr_o  = wr_addr;
        ram_we_o    = 1'b1;
        ram_mask_o  = 4'b0001 << wr_x_i[1:0];
        ram_wdata_o = {4{wr_pix_i}};
      end
    end
  end

  // Clear engine and writer drop flag. The counter only advances on cycles
  // where the clear actually owned the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clr_busy_o <= 1'b0;
      wr_drop_o  <= 1'b0;
      clr_addr   <= '0;
    end else begin
      wr_drop_o <= wr_fire && !wr_in_range;
      case (state)
        IDLE: begin
          if (clr_start_i) begin
            state      <= CLEAR;
            clr_busy_o <= 1'b1;
            clr_addr   <= '0;
            clr_color  <= clr_color_i;
          end
        end
        CLEAR: begin
          if (!slot) begin
            if (clr_addr == fb_addr_t'(FB_WORDS - 1)) begin
              state      <= IDLE;
              clr_busy_o <= 1'b0;
            end else begin
              clr_addr <= clr_addr + 15'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_i, y_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [8:0]  wr_x_i;
  logic [7:0]  wr_y_i;
  logic [3:0]  wr_pix_i;
  logic        wr_drop_o;
  logic        clr_start_i;
  logic [3:0]  clr_color_i;
  logic        clr_busy_o;
  logic [14:0] ram_addr_o;
  logic        ram_we_o;
  logic [3:0]  ram_mask_o;
  logic [15:0] ram_wdata_o;
  logic [15:0] ram_rdata_i = 16'h0;
  logic [3:0]  pix_o;
  logic        active_o;

  int vectors = 0;
  int miscompares = 0;

  fb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .x_i         (x_i),
    .y_i         (y_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_x_i      (wr_x_i),
    .wr_y_i      (wr_y_i),
    .wr_pix_i    (wr_pix_i),
    .wr_drop_o   (wr_drop_o),
    .clr_start_i (clr_start_i),
    .clr_color_i (clr_color_i),
    .clr_busy_o  (clr_busy_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_mask_o  (ram_mask_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .pix_o       (pix_o),
    .active_o    (active_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial framebuffer contents, shared by the RAM emulation and the model.
  function automatic logic [15:0] init_word(input int a);
    case (a)
      0:       return 16'h4321;
      1:       return 16'h8765;
      80:      return 16'hFEDC;
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- RAM emulation (1-cycle read latency) ----------------
  logic [15:0] mem [0:19199];
  logic        ram_loaded = 1'b0;

  always @(posedge clk) begin : ram
    logic [15:0] w;
    if (!ram_loaded) begin
      for (int a = 0; a < 19200; a++) mem[a] = init_word(a);
      ram_loaded = 1'b1;
    end
    if (ram_addr_o < 15'd19200) ram_rdata_i <= mem[ram_addr_o];
    else                        ram_rdata_i <= 16'h0;
    if (ram_we_o && ram_addr_o < 15'd19200) begin
      w = mem[ram_addr_o];
      for (int k = 0; k < 4; k++)
        if (ram_mask_o[k]) w[4*k +: 4] = ram_wdata_o[4*k +: 4];
      mem[ram_addr_o] = w;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // Framebuffer kept as a plain 2-D pixel array; the clear is a list of word
  // addresses consumed one per free cycle.
  logic [3:0] fbm [0:239][0:319];
  logic       fb_loaded = 1'b0;
  logic       busy_m, drop_m;
  int         clr_next;
  logic [3:0] color_m;
  logic [3:0] grp [0:3];
  logic       h1_act, h2_act;
  logic [3:0] h1_pix, h2_pix;

  always @(negedge clk) begin : cmp
    logic       slot_e, vis_e, ready_e, fire_e, inr_e;
    logic [3:0] ent_pix;
    logic [15:0] w;
    vis_e  = (x_i < 640) && (y_i < 480);
    slot_e = vis_e && (x_i % 8 == 0);
    if (reset) begin
      chk("we_in_reset", ram_we_o, 0);
      if (!fb_loaded) begin
        for (int a = 0; a < 19200; a++) begin
          w = init_word(a);
          for (int k = 0; k < 4; k++) fbm[a / 80][(a % 80) * 4 + k] = w[4*k +: 4];
        end
        fb_loaded = 1'b1;
      end
      busy_m = 0; drop_m = 0;
      h1_act = 0; h2_act = 0; h1_pix = 0; h2_pix = 0;
      for (int k = 0; k < 4; k++) grp[k] = 4'h0;
    end else begin
      ready_e = !slot_e && !busy_m;
      fire_e  = wr_valid_i && ready_e;
      inr_e   = (wr_x_i < 320) && (wr_y_i < 240);
      chk("wr_ready", wr_ready_o, ready_e);
      chk("clr_busy", clr_busy_o, busy_m);
      chk("wr_drop", wr_drop_o, drop_m);
      chk("pix", pix_o, h2_pix);
      chk("active", active_o, h2_act);
      if (slot_e) begin
        chk("fetch_we", ram_we_o, 0);
        chk("fetch_addr", ram_addr_o, (y_i / 2) * 80 + x_i / 8);
      end else if (busy_m) begin
        chk("clr_we", ram_we_o, 1);
        chk("clr_addr", ram_addr_o, clr_next);
        chk("clr_mask", ram_mask_o, 15);
        chk("clr_wdata", ram_wdata_o, {4{color_m}});
      end else if (fire_e && inr_e) begin
        chk("wr_we", ram_we_o, 1);
        chk("wr_addr", ram_addr_o, wr_y_i * 80 + wr_x_i / 4);
        chk("wr_mask", ram_mask_o, 1 << (wr_x_i % 4));
        chk("wr_wdata", ram_wdata_o, {4{wr_pix_i}});
      end else begin
        chk("idle_we", ram_we_o, 0);
        chk("idle_mask", ram_mask_o, 0);
      end
      // display: capture the 4 framebuffer pixels of the group on a slot
      if (slot_e)
        for (int k = 0; k < 4; k++) grp[k] = fbm[y_i / 2][(x_i / 8) * 4 + k];
      ent_pix = vis_e ? grp[(x_i / 2) % 4] : 4'h0;
      h2_act = h1_act; h2_pix = h1_pix;
      h1_act = vis_e;  h1_pix = ent_pix;
      // state advance
      drop_m = fire_e && !inr_e;
      if (fire_e && inr_e) fbm[wr_y_i][wr_x_i] = wr_pix_i;
      if (busy_m) begin
        if (!slot_e) begin
          for (int k = 0; k < 4; k++) fbm[clr_next / 80][(clr_next % 80) * 4 + k] = color_m;
          clr_next++;
          if (clr_next == 19200) busy_m = 0;
        end
      end else if (clr_start_i) begin
        busy_m = 1; clr_next = 0; color_m = clr_color_i;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [3:0] exp_pix [0:7];
  int  busy_cycles, sx, sy;
  logic done, found;

  initial begin
    exp_pix = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
    reset = 1'b1; x_i = 10'd700; y_i = 10'd500;
    wr_valid_i = 0; wr_x_i = 0; wr_y_i = 0; wr_pix_i = 0;
    clr_start_i = 0; clr_color_i = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    smp();
    chk("rst_pix", pix_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_busy", clr_busy_o, 0);
    chk("rst_drop", wr_drop_o, 0);
    chk("rst_we", ram_we_o, 0);

    // scan row 0, with writer transfers mixed in
    for (int k = 0; k < 12; k++) begin
      nxt();
      x_i = 10'(k); y_i = 10'd0;
      wr_valid_i = (k == 3) || (k == 8) || (k == 9);
      if (k == 3) begin wr_x_i = 9'd5; wr_y_i = 8'd1; wr_pix_i = 4'hA; end
      else begin wr_x_i = 9'd2; wr_y_i = 8'd3; wr_pix_i = 4'h6; end
      smp();
      if (k == 0) begin
        chk("sweep_addr0", ram_addr_o, 0);
        chk("sweep_we0", ram_we_o, 0);
      end
      if (k >= 2 && k <= 9) begin
        chk("sweep_pix", pix_o, exp_pix[k-2]);
        chk("sweep_active", active_o, 1);
      end
      if (k == 3) begin
        chk("wr3_ready", wr_ready_o, 1);
        chk("wr3_addr", ram_addr_o, 81);
        chk("wr3_mask", ram_mask_o, 4'b0010);
        chk("wr3_wdata", ram_wdata_o, 16'hAAAA);
        chk("wr3_we", ram_we_o, 1);
      end
      if (k == 8) begin
        chk("slot_ready", wr_ready_o, 0);
        chk("slot_addr", ram_addr_o, 1);
        chk("slot_we", ram_we_o, 0);
      end
      if (k == 9) begin
        chk("after_slot_ready", wr_ready_o, 1);
        chk("after_slot_we", ram_we_o, 1);
        chk("after_slot_addr", ram_addr_o, 240);
        chk("after_slot_mask", ram_mask_o, 4'b0100);
      end
    end

    // out-of-range writes and the last in-range pixel
    nxt(); wr_valid_i = 1; x_i = 10'd700; wr_x_i = 9'd320; wr_y_i = 8'd0; wr_pix_i = 4'h5;
    smp(); chk("drop_x_ready", wr_ready_o, 1); chk("drop_x_we", ram_we_o, 0);
    nxt(); wr_valid_i = 0;
    smp(); chk("drop_x_pulse", wr_drop_o, 1);
    nxt();
    smp(); chk("drop_x_end", wr_drop_o, 0);
    nxt(); wr_valid_i = 1; wr_x_i = 9'd0; wr_y_i = 8'd240;
    smp(); chk("drop_y_ready", wr_ready_o, 1); chk("drop_y_we", ram_we_o, 0);
    nxt(); wr_valid_i = 0;
    smp(); chk("drop_y_pulse", wr_drop_o, 1);
    nxt(); wr_valid_i = 1; wr_x_i = 9'd319; wr_y_i = 8'd239; wr_pix_i = 4'h9;
    smp();
    chk("corner_we", ram_we_o, 1);
    chk("corner_addr", ram_addr_o, 19199);
    chk("corner_mask", ram_mask_o, 4'b1000);
    chk("corner_wdata", ram_wdata_o, 16'h9999);
    nxt(); wr_valid_i = 0;
    smp(); chk("corner_nodrop", wr_drop_o, 0);

    // write and clear start together, then reset mid-clear at address 100
    nxt(); wr_valid_i = 1; wr_x_i = 9'd1; wr_y_i = 8'd0; wr_pix_i = 4'h3;
    clr_start_i = 1; clr_color_i = 4'h2;
    smp();
    chk("both_we", ram_we_o, 1); chk("both_addr", ram_addr_o, 0); chk("both_mask", ram_mask_o, 4'b0010);
    nxt(); wr_valid_i = 0; clr_start_i = 0;
    smp();
    chk("clr_first_busy", clr_busy_o, 1); chk("clr_first_addr", ram_addr_o, 0);
    chk("clr_first_wdata", ram_wdata_o, 16'h2222);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (ram_we_o && ram_addr_o == 15'd100) found = 1;
      else begin nxt(); smp(); end
    end
    chk("reach_addr100", found, 1);
    nxt(); reset = 1;
    smp(); chk("midrst_we", ram_we_o, 0);
    nxt(); reset = 0;
    smp();
    chk("midrst_busy", clr_busy_o, 0); chk("midrst_we_after", ram_we_o, 0);
    chk("midrst_ready", wr_ready_o, 1);
    chk("partial_100", mem[100], 16'h2222);
    chk("partial_101", mem[101], 16'h0000);
    chk("partial_0", mem[0], 16'h2222);
    nxt(); clr_start_i = 1; clr_color_i = 4'h5;
    smp();
    nxt(); clr_start_i = 0;
    smp(); chk("restart_addr", ram_addr_o, 0); chk("restart_wdata", ram_wdata_o, 16'h5555);
    nxt();
    smp(); chk("restart_addr1", ram_addr_o, 1);
    nxt(); reset = 1;
    nxt(); reset = 0;

    // full clear starting at the top of a frame with a live scan
    nxt(); x_i = 10'd799; y_i = 10'd10; clr_start_i = 1; clr_color_i = 4'h7;
    smp();
    nxt(); clr_start_i = 0; sx = 0; sy = 0; x_i = 10'd0; y_i = 10'd0;
    busy_cycles = 0; done = 0;
    wr_x_i = 9'd300; wr_y_i = 8'd239; wr_pix_i = 4'h1;
    for (int n = 0; n < 30000 && !done; n++) begin
      smp();
      if (clr_busy_o) busy_cycles++;
      else done = 1;
      if (!done) begin
        nxt();
        sx++;
        if (sx == 800) begin sx = 0; sy = (sy == 524) ? 0 : sy + 1; end
        x_i = 10'(sx); y_i = 10'(sy);
        wr_valid_i  = (n % 37 == 0);
        clr_start_i = (n == 5000);
        clr_color_i = 4'h3;
      end
    end
    chk("clr_done", done, 1);
    chk("clr_busy_cycles", busy_cycles, 21349);
    nxt(); wr_valid_i = 0; clr_start_i = 0;
    smp();
    chk("cleared_0", mem[0], 16'h7777);
    chk("cleared_9600", mem[9600], 16'h7777);
    chk("cleared_19199", mem[19199], 16'h7777);

    // cleared screen on the display
    for (int k = 0; k < 10; k++) begin
      nxt(); x_i = 10'(k); y_i = 10'd1;
      smp();
      if (k >= 2) chk("cleared_pix", pix_o, 7);
    end

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Shares one 16-bit-wide framebuffer RAM (SPRAM, 320x240 at 4 bpp, 19200 words) between VGA scan-out and a pixel writer. Sits between the VGA timing controller (x, y inputs) and the colour lookup (pix_o, active_o). Display fetch has absolute priority; the writer and a screen-clear FSM use the remaining cycles. Everything runs in the vgaclk domain.

Parameters:
H_ACTIVE, 640, visible screen width in VGA pixels
V_ACTIVE, 480, visible screen height in VGA lines
FB_W, 320, framebuffer width in pixels (2x horizontal scale)
FB_H, 240, framebuffer height in pixels (2x vertical scale)

Ports:
clk  in  1  pixel clock (vgaclk)
reset  in  1  synchronous, active-high
x_i  in  10  current scan column from the timing controller
y_i  in  10  current scan row from the timing controller
wr_valid_i  in  1  writer request
wr_ready_o  out  1  writer request accepted this cycle
wr_x_i  in  9  framebuffer column
wr_y_i  in  8  framebuffer row
wr_pix_i  in  4  pixel value
wr_drop_o  out  1  one-cycle pulse: accepted write was out of range and discarded
clr_start_i  in  1  start screen clear
clr_color_i  in  4  fill value, sampled on start
clr_busy_o  out  1  clear in progress
ram_addr_o  out  15  word address
ram_we_o  out  1  write enable
ram_mask_o  out  4  per-nibble write mask
ram_wdata_o  out  16  write data
ram_rdata_i  in  16  read data, valid 1 cycle after the address is presented
pix_o  out  4  pixel for (x_i, y_i) sampled 2 cycles earlier
active_o  out  1  pix_o is inside the visible area

Behaviour:
- Pixel packing: word address = y*80 + (x>>2). Pixel k = x%4 is stored in bits [4k+3:4k]; mask bit k selects it. Multiply by 80 as (y<<6)+(y<<4); no multiplier.
- Fetch slot: x_i<H_ACTIVE && y_i<V_ACTIVE && x_i[2:0]==0.
  - In a slot: ram_addr_o=(y_i>>1)*80+(x_i>>3), ram_we_o=0.
  - Exactly 1 of every 8 visible cycles is a slot. Every non-slot cycle, including all blanking, is free.
- Display pipe: latency is fixed at 2 cycles.
  - pix_o = nibble ((x>>1)%4) of the word fetched for that 8-pixel group, x/y being the inputs 2 cycles earlier.
  - The fetched word is held until the next slot.
  - Outside the visible area: pix_o=0, active_o=0.
- Writer handshake:
  - wr_ready_o = !slot && state==IDLE. This is combinational.
  - A transfer occurs when wr_valid_i && wr_ready_o.
  - In-range transfer: ram_we_o=1, addr per packing, mask one-hot at wr_x_i%4, wdata = wr_pix_i replicated x4. Single cycle; no read-modify-write.
  - Out of range (wr_x_i>=FB_W or wr_y_i>=FB_H): the transfer is still accepted, ram_we_o=0, and wr_drop_o pulses the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE->CLEAR on clr_start_i: clear counter=0, colour latched, clr_busy_o=1 from the next cycle.
  - In CLEAR, each free cycle writes counter address with mask 4'hF and colour x4, then increments the counter. Slot cycles stall the counter.
  - CLEAR->IDLE after address 19199 is written; clr_busy_o falls the next cycle.
  - clr_start_i while in CLEAR is ignored.
  - clr_start_i with a writer transfer in the same IDLE cycle: the write completes, the clear begins next cycle and overwrites it.
- Reset values: state IDLE, clr_busy_o=0, wr_drop_o=0, pix_o=0, active_o=0, held word=0.
  - ram_we_o=0 during any cycle with reset high.
  - Reset mid-clear aborts immediately and leaves RAM partially cleared.
- Unused cycles: ram_we_o=0, ram_addr_o don't-care, mask 0.

Decomposition:
- Package fb_pkg holds:
  - constants FB_W, FB_H, WORDS_PER_ROW=80, FB_WORDS=19200, PIX_W=4
  - typedefs pix_t [3:0], fb_word_t [15:0], fb_addr_t [14:0]
  - enum clr_state_t {IDLE, CLEAR}
- One sub-module, fb_scan_pipe: slot detection, display address, held word, 2-stage pixel/active output.
- Top level: writer/clear arbitration and the RAM mux.

Test Plan:
- Word 0=16'h4321; sweep x_i=0..7, y_i=0 -> ram_addr_o=0 at x=0; pix_o=1,1,2,2,3,3,4,4 with 2-cycle lag; active_o=1.
- wr x=5,y=1,pix=A at x_i=3 (non-slot) -> wr_ready_o=1, ram_addr_o=81, mask=4'b0010, wdata=16'hAAAA, we=1.
- wr_valid held across x_i=8,y_i=0 (slot) -> wr_ready_o=0, ram_addr_o=1, we=0; transfer completes at x_i=9.
- clr_start colour 7 at top of frame -> writes addr 0..19199, mask F, wdata 7777, no writes in slot cycles; busy for 19200 + slot-count cycles; wr_ready_o=0 throughout.
- wr x=320,y=0 -> accepted, we=0, wr_drop_o pulse 1 cycle later; y=240 same.
- reset at clear address 100 -> clr_busy_o=0, state IDLE, ram_we_o=0 next cycle; a new clr_start restarts at address 0.
